reboot_request_ctrl: RTL and testbench
======================================

# reboot_request_ctrl

Upstream companion of the multiboot ICAP sequencer. Accepts a guarded byte command from the loader's command path: unlock key 0x55, 0xAA, then a slot number. It computes the 24-bit SPI flash address of the selected bitstream slot and holds it stable on `SPI_ADDR`. After a hold-off delay it emits a clean `REBOOT` pulse followed by a low tail, which satisfies the sequencer's falling-edge detector (REBOOT high, then low for at least 3 consecutive cycles).

## Interface
Parameters:
- SLOT_BASE, 24'h000000, flash address of slot 0 (golden image)
- SLOT_SIZE, 24'h080000, address stride between slots
- NUM_SLOTS, 4, number of valid slots (1..256)
- HOLDOFF, 1024, cycles between slot acceptance and REBOOT rise (0 allowed)
- PULSE_LEN, 8, REBOOT high time in cycles (≥1)
- TIMEOUT, 65535, max idle cycles between key/slot bytes (≥1)

Ports:
- CLK  in  1  single clock, same domain as the ICAP sequencer
- RESET  in  1  synchronous, active-high reset
- CMD_VALID  in  1  command byte valid
- CMD_DATA  in  8  command byte
- CMD_READY  out  1  block can accept a byte
- SPI_ADDR  out  24  registered slot address, feeds the sequencer's `spi_addr`
- REBOOT  out  1  registered reboot request, feeds the sequencer's `REBOOT`
- BUSY  out  1  high in HOLD, PULSE and TAIL
- ERR  out  1  one-cycle pulse on bad key, bad slot, or timeout

## Operation
- A byte is accepted on a rising edge where CMD_VALID && CMD_READY. CMD_READY = 1 in IDLE, KEY1 and KEY2; 0 otherwise. CMD_READY is a combinational decode of the state.
- IDLE: byte 0x55 → KEY1. Any other byte is dropped with no ERR.
- KEY1: byte 0xAA → KEY2. Byte 0x55 → stay in KEY1 and restart the timeout. Any other byte → IDLE with ERR.
- KEY2: byte s < NUM_SLOTS → HOLD. SPI_ADDR ← SLOT_BASE + s*SLOT_SIZE, truncated to 24 bits. Byte s ≥ NUM_SLOTS → IDLE with ERR; SPI_ADDR is unchanged.
- Timeout counter: cleared on every accepted byte and incremented each cycle in KEY1/KEY2. When it reaches TIMEOUT, go to IDLE with ERR.
- HOLD: count HOLDOFF cycles, then → PULSE. With HOLDOFF = 0, go straight to PULSE.
- PULSE: REBOOT = 1 for exactly PULSE_LEN cycles, then → TAIL.
- TAIL: REBOOT = 0 for exactly 4 cycles, then → IDLE.
- SPI_ADDR changes only on slot acceptance or RESET. It is stable through HOLD/PULSE/TAIL and afterwards.
- Bytes presented while CMD_READY = 0 are not consumed. The upstream must hold them.
- Reset values (at the first edge with RESET = 1):
  - state IDLE
  - REBOOT 0, BUSY 0, ERR 0
  - CMD_READY 1
  - SPI_ADDR = SLOT_BASE
  - all counters 0
- RESET overrides every other event in the same cycle.
- RESET during PULSE drops REBOOT and sets SPI_ADDR to SLOT_BASE at the same edge. The sequencer then sees a falling edge with the golden address, and the fail-safe reboot goes to slot 0. This is intended.

## Timing
- Let t0 be the edge that accepts a valid slot byte.
- SPI_ADDR and BUSY update at t0; BUSY is 1 from t0.
- REBOOT rises at edge t0+HOLDOFF+1 and falls at t0+HOLDOFF+1+PULSE_LEN.
- The state returns to IDLE at the edge 4 cycles after the fall. CMD_READY = 1 and BUSY = 0 from that edge.
- Result: SPI_ADDR is stable for ≥1 cycle before REBOOT rises and through the sequencer's detection window.
- ERR is high for the single cycle following the offending edge (bad byte or timeout).
- Timeout: with the last byte accepted at edge tb, ERR is asserted and the state returns to IDLE at edge tb+TIMEOUT.
- Throughput: one byte per cycle in IDLE/KEY1/KEY2.

## Test plan
- Reset, then send 0x55, 0xAA, 0x01 back-to-back (HOLDOFF = 4, PULSE_LEN = 8). Required response:
  - SPI_ADDR = 24'h080000 one cycle after the slot byte.
  - REBOOT high cycles t0+5..t0+12, then low.
  - CMD_READY = 0 until TAIL ends, then back in IDLE.
- Send 0x55, 0x12 → ERR pulse, state IDLE, SPI_ADDR unchanged. Then send 0x55, 0x55, 0xAA, 0x03 → SPI_ADDR = 24'h180000 and the reboot pulse occurs.
- Send 0x55, 0xAA, 0x04 with NUM_SLOTS = 4 → ERR, no REBOOT, SPI_ADDR unchanged.
- Send 0x55, then idle for TIMEOUT cycles (TIMEOUT = 16 in test) → ERR at exactly tb+16, state IDLE. A following 0xAA is dropped, so no KEY2.
- Hold CMD_VALID high with 0x55 through HOLD/PULSE → no byte is consumed and no state change until IDLE.
- Assert RESET in the middle of PULSE (SPI_ADDR was 24'h100000) → REBOOT = 0 and SPI_ADDR = 24'h000000 at the same edge, BUSY = 0, CMD_READY = 1.

Source files
------------

// File: rtl/reboot_request_ctrl.sv
// reboot_request_ctrl
// Guarded reboot request front end for the multiboot ICAP sequencer.
// A byte command 0x55, 0xAA, <slot> selects a bitstream slot. The slot's
// SPI flash address is latched onto o_spi_addr. After HOLDOFF cycles a
// PULSE_LEN-cycle o_reboot pulse is emitted, followed by a 4-cycle low tail.
//
// Ports:
//   i_clk        single clock, same domain as the ICAP sequencer
//   i_rst        synchronous active-high reset
//   i_cmd_valid  command byte valid
//   i_cmd_data   command byte
//   o_cmd_ready  byte can be accepted (IDLE/KEY1/KEY2)
//   o_spi_addr   registered slot flash address
//   o_reboot     registered reboot request
//   o_busy       high in HOLD, PULSE and TAIL
//   o_err        one-cycle pulse on bad key, bad slot or timeout
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | waiting for unlock byte 0x55
// ST_KEY1  | 0x55 seen, waiting for 0xAA (timeout running)
// ST_KEY2  | key complete, waiting for slot number (timeout running)
// ST_HOLD  | slot latched, counting hold-off before reboot
// ST_PULSE | o_reboot high for PULSE_LEN cycles
// ST_TAIL  | o_reboot low for 4 cycles so the sequencer sees the fall

module reboot_request_ctrl #(
  parameter logic [23:0] SLOT_BASE = 24'h000000,
  parameter logic [23:0] SLOT_SIZE = 24'h080000,
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned HOLDOFF   = 1024,
  parameter int unsigned PULSE_LEN = 8,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  input  logic [7:0]  i_cmd_data,
  output logic        o_cmd_ready,
  output logic [23:0] o_spi_addr,
  output logic        o_reboot,
  output logic        o_busy,
  output logic        o_err
);

  localparam int unsigned MAX_A   = (HOLDOFF > PULSE_LEN) ? HOLDOFF : PULSE_LEN;
  localparam int unsigned MAX_B   = (MAX_A > TIMEOUT) ? MAX_A : TIMEOUT;
  localparam int unsigned CNT_MAX = (MAX_B > 3) ? MAX_B : 3;
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);

  // One shared down-counter; each load value is "cycles remaining - 1"
  // except hold-off, which spends one extra cycle in HOLD so that the
  // reboot rises at t0 + HOLDOFF + 1 (HOLDOFF = 0 gives one HOLD cycle).
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLDOFF);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] TO_LD    = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TAIL_LD  = CNT_W'(3);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY1,
    ST_KEY2,
    ST_HOLD,
    ST_PULSE,
    ST_TAIL
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [23:0]      r_addr;
  logic             r_reboot;
  logic             r_busy;
  logic             r_err;

  logic             w_accept;
  logic             w_slot_ok;
  logic             w_cnt_zero;
  logic [23:0]      w_slot_addr;

  assign o_cmd_ready = (r_state == ST_IDLE) || (r_state == ST_KEY1) || (r_state == ST_KEY2);
  assign w_accept    = i_cmd_valid && o_cmd_ready;
  assign w_slot_ok   = 32'(i_cmd_data) < NUM_SLOTS;
  assign w_cnt_zero  = (r_cnt == '0);
  // Product wraps modulo 2^24, matching the flash address width.
  assign w_slot_addr = SLOT_BASE + (24'(i_cmd_data) * SLOT_SIZE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_addr   <= SLOT_BASE;
      r_reboot <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept && (i_cmd_data == 8'h55)) begin
            r_state <= ST_KEY1;
            r_cnt   <= TO_LD;
          end
        end
        ST_KEY1: begin
          if (w_accept) begin
            if (i_cmd_data == 8'hAA) begin
              r_state <= ST_KEY2;
              r_cnt   <= TO_LD;
            end else if (i_cmd_data == 8'h55) begin
              r_cnt <= TO_LD;
            end else begin
              r_state <= ST_IDLE;
              r_err   <= 1'b1;
            end
          end else if (w_cnt_zero) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_KEY2: begin
          if (w_accept) begin
            if (w_slot_ok) begin
              r_state <= ST_HOLD;
              r_addr  <= w_slot_addr;
              r_busy  <= 1'b1;
              r_cnt   <= HOLD_LD;
            end else begin
              r_state <= ST_IDLE;
              r_err   <= 1'b1;
            end
          end else if (w_cnt_zero) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (w_cnt_zero) begin
            r_state  <= ST_PULSE;
            r_reboot <= 1'b1;
            r_cnt    <= PULSE_LD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_PULSE: begin
          if (w_cnt_zero) begin
            r_state  <= ST_TAIL;
            r_reboot <= 1'b0;
            r_cnt    <= TAIL_LD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_TAIL: begin
          if (w_cnt_zero) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_reboot <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign o_spi_addr = r_addr;
  assign o_reboot   = r_reboot;
  assign o_busy     = r_busy;
  assign o_err      = r_err;

endmodule

// File: tb/tb_reboot_request_ctrl.sv
// Testbench for reboot_request_ctrl: directed command sequences followed by
// randomized traffic, all checked every cycle against a timestamp-based
// reference model of the command protocol and reboot timing.

module tb_reboot_request_ctrl;

  localparam int          H    = 4;
  localparam int          P    = 8;
  localparam int          TO   = 16;
  localparam int          NS   = 4;
  localparam logic [23:0] BASE = 24'h000000;
  localparam logic [23:0] SIZE = 24'h080000;

  logic        clk = 1'b0;
  logic        rst;
  logic        v;
  logic [7:0]  d;
  logic        ready;
  logic [23:0] addr;
  logic        reboot;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  reboot_request_ctrl #(
    .SLOT_BASE(BASE), .SLOT_SIZE(SIZE), .NUM_SLOTS(NS),
    .HOLDOFF(H), .PULSE_LEN(P), .TIMEOUT(TO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(v), .i_cmd_data(d),
    .o_cmd_ready(ready), .o_spi_addr(addr), .o_reboot(reboot),
    .o_busy(busy), .o_err(err)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  // Reference model: key progress (bytes of the unlock key matched), cycle of
  // the last accepted byte, and the cycle a slot was accepted. Busy/reboot
  // are derived purely from the slot-acceptance timestamp.
  logic [23:0] m_addr  = BASE;
  int          m_keys  = 0;
  int          m_last  = 0;
  int          m_t0    = 0;
  bit          m_t0_ok = 1'b0;
  logic        m_err   = 1'b0;

  function automatic bit busy_at(int c);
    return m_t0_ok && (c >= m_t0) && (c < m_t0 + H + P + 5);
  endfunction

  function automatic bit reboot_at(int c);
    return m_t0_ok && (c >= m_t0 + H + 1) && (c < m_t0 + H + 1 + P);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge(input logic vi, input logic [7:0] di, input logic ri);
    bit acc;
    if (ri) begin
      m_addr  = BASE;
      m_keys  = 0;
      m_t0_ok = 1'b0;
      m_err   = 1'b0;
    end else begin
      m_err = 1'b0;
      acc   = vi && !busy_at(cyc - 1);
      if (acc) begin
        if (m_keys == 0) begin
          if (di == 8'h55) begin m_keys = 1; m_last = cyc; end
        end else if (m_keys == 1) begin
          if (di == 8'hAA) begin m_keys = 2; m_last = cyc; end
          else if (di == 8'h55) m_last = cyc;
          else begin m_keys = 0; m_err = 1'b1; end
        end else begin
          m_keys = 0;
          if (int'(di) < NS) begin
            m_addr  = 24'((int'(BASE) + int'(di) * int'(SIZE)) & 32'h00FF_FFFF);
            m_t0    = cyc;
            m_t0_ok = 1'b1;
          end else m_err = 1'b1;
        end
      end else if (m_keys != 0 && (cyc - m_last) >= TO) begin
        m_keys = 0;
        m_err  = 1'b1;
      end
    end
  endtask

  task automatic step(input logic vi, input logic [7:0] di, input logic ri);
    rst = ri;
    v   = vi;
    d   = di;
    @(posedge clk);
    cyc++;
    model_edge(vi, di, ri);
    @(negedge clk);
    chk("spi_addr",  32'(addr),   32'(m_addr));
    chk("reboot",    32'(reboot), 32'(reboot_at(cyc)));
    chk("busy",      32'(busy),   32'(busy_at(cyc)));
    chk("cmd_ready", 32'(ready),  32'(!busy_at(cyc)));
    chk("err",       32'(err),    32'(m_err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int first;
    int highs;
    int quiet;
    int r;
    logic       rv;
    logic [7:0] rd;

    rst = 1'b1; v = 1'b0; d = 8'h00;
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("rst_addr",  32'(addr),  32'h0);
    chk("rst_ready", 32'(ready), 32'h1);
    step(1'b0, 8'h00, 1'b0);

    // Slot 1, back-to-back bytes
    step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    chk("slot1_addr", 32'(addr), 32'h080000);
    chk("slot1_busy", 32'(busy), 32'h1);
    first = -1; highs = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 8'h00, 1'b0);
      if (reboot) begin
        highs++;
        if (first < 0) first = k;
      end
    end
    chk("pulse_rise", 32'(first), 32'd5);
    chk("pulse_len",  32'(highs), 32'd8);

    // Bad key byte, then repeated 0x55 before key completes
    step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'h12, 1'b0);
    chk("badkey_err",  32'(err),  32'h1);
    chk("badkey_addr", 32'(addr), 32'h080000);
    step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'h03, 1'b0);
    chk("slot3_addr", 32'(addr), 32'h180000);
    idle(20);

    // Out-of-range slot
    step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'h04, 1'b0);
    chk("badslot_err",  32'(err),  32'h1);
    chk("badslot_addr", 32'(addr), 32'h180000);
    idle(3);

    // Timeout after a lone 0x55
    step(1'b1, 8'h55, 1'b0);
    for (int k = 1; k <= TO; k++) begin
      step(1'b0, 8'h00, 1'b0);
      if (k == TO - 1) chk("to_early_err", 32'(err), 32'h0);
    end
    chk("to_err", 32'(err), 32'h1);
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    chk("to_no_key2", 32'(addr), 32'h180000);

    // CMD_VALID held with 0x55 through HOLD/PULSE/TAIL
    step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b1, 8'h55, 1'b0);
    idle(TO + 2);

    // Reset in the middle of the pulse
    step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    chk("slot2_addr", 32'(addr), 32'h100000);
    idle(7);
    chk("mid_pulse", 32'(reboot), 32'h1);
    step(1'b0, 8'h00, 1'b1);
    chk("rstp_reboot", 32'(reboot), 32'h0);
    chk("rstp_addr",   32'(addr),   32'h000000);
    chk("rstp_busy",   32'(busy),   32'h0);
    chk("rstp_ready",  32'(ready),  32'h1);
    step(1'b0, 8'h00, 1'b0);

    // Randomized traffic, biased towards completing commands
    quiet = 0;
    for (int i = 0; i < 4000; i++) begin
      if (quiet > 0) begin
        quiet--;
        step(1'b0, 8'($urandom), 1'b0);
      end else if ($urandom_range(0, 39) == 0) begin
        quiet = int'($urandom_range(10, 20));
        step(1'b0, 8'h00, 1'b0);
      end else if ($urandom_range(0, 499) == 0) begin
        step(1'($urandom), 8'($urandom), 1'b1);
      end else begin
        rv = ($urandom_range(0, 9) < 7);
        r  = int'($urandom_range(0, 9));
        if (m_keys == 1 && r < 6)      rd = 8'hAA;
        else if (m_keys == 2 && r < 7) rd = 8'($urandom_range(0, 5));
        else if (r < 3)                rd = 8'h55;
        else if (r < 5)                rd = 8'hAA;
        else if (r < 9)                rd = 8'($urandom_range(0, 5));
        else                           rd = 8'($urandom);
        step(rv, rd, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
